// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independent integer clock dividers with runtime reconfiguration
// Settings change only at period boundaries, so divided clocks never glitch or truncate a phase.
module clk_div_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 2,
    parameter int RESET_EN  = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CH_W-1:0]      cfg_ch_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_en_i,
    output logic                 cfg_err_o,
    output logic [NUM_CH-1:0]    div_clk_o,
    output logic [NUM_CH-1:0]    tick_o,
    output logic [NUM_CH-1:0]    pend_o,
    output logic [NUM_CH-1:0]    cfg_done_o
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
    localparam logic                 RST_EN  = (RESET_EN != 0);

    logic              first_q;
    logic              err_q;
    logic              cfg_fire;
    logic              pend_sel;
    logic [NUM_CH-1:0] pend_v;

    // Out-of-range channels have no pending slot, so they always read as ready.
    always_comb begin
        pend_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(cfg_ch_i) == c) begin
                pend_sel = pend_v[c];
            end
        end
    end

    assign cfg_ready_o = !rst_i && !pend_sel;
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign cfg_err_o   = err_q;
    assign pend_o      = pend_v;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            first_q <= 1'b0;
            err_q   <= cfg_fire && (int'(cfg_ch_i) >= NUM_CH);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                 active_q, active_n;
        logic [DIV_WIDTH-1:0] div_q, div_n;
        logic [DIV_WIDTH-1:0] cnt_q, cnt_n;
        logic [DIV_WIDTH-1:0] pdiv_q, pdiv_n;
        logic [DIV_WIDTH-1:0] half_n;
        logic                 pv_q, pv_n;
        logic                 pen_q, pen_n;
        logic                 clk_q, tick_q, done_q, done_n;
        logic                 acc, boundary;

        assign acc      = cfg_fire && (int'(cfg_ch_i) == c);
        assign boundary = (div_q <= DIV_WIDTH'(1)) || (cnt_q == div_q - DIV_WIDTH'(1));
        assign half_n   = div_n >> 1;

        always_comb begin
            active_n = active_q;
            div_n    = div_q;
            cnt_n    = cnt_q;
            pv_n     = pv_q;
            pdiv_n   = pdiv_q;
            pen_n    = pen_q;
            done_n   = 1'b0;
            if (!active_q) begin
                // A halted channel has no phase to protect, so config bypasses pending.
                cnt_n = '0;
                if (first_q) begin
                    active_n = RST_EN;
                end
                if (acc) begin
                    div_n    = cfg_div_i;
                    active_n = cfg_en_i;
                    done_n   = 1'b1;
                end
            end else begin
                if (boundary) begin
                    cnt_n = '0;
                    if (pv_q) begin
                        div_n    = pdiv_q;
                        active_n = pen_q;
                        pv_n     = 1'b0;
                        done_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + DIV_WIDTH'(1);
                end
                // Only reachable with the slot empty; applies at the next boundary.
                if (acc) begin
                    pv_n   = 1'b1;
                    pdiv_n = cfg_div_i;
                    pen_n  = cfg_en_i;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                active_q <= 1'b0;
                div_q    <= RST_DIV;
                cnt_q    <= '0;
                pv_q     <= 1'b0;
                pdiv_q   <= '0;
                pen_q    <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                active_q <= active_n;
                div_q    <= div_n;
                cnt_q    <= cnt_n;
                pv_q     <= pv_n;
                pdiv_q   <= pdiv_n;
                pen_q    <= pen_n;
                clk_q    <= active_n && (cnt_n < half_n);
                tick_q   <= active_n && (cnt_n == '0);
                done_q   <= done_n;
            end
        end

        assign div_clk_o[c]  = clk_q;
        assign tick_o[c]     = tick_q;
        assign cfg_done_o[c] = done_q;
        assign pend_v[c]     = pv_q;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NUM_CH independent integer clock dividers, all derived from one fast clock, for SoC/peripheral/slow-timer domains that do not need a dedicated FLL. Each channel produces a register-driven divided clock and a one-cycle tick strobe. Divide ratio and enable are reprogrammed at runtime through a valid/ready config port. Every change takes effect only at a period boundary, so output clocks never glitch or truncate a phase.

## Interface
- NUM_CH, 4: number of divider channels (1..32)
- DIV_WIDTH, 8: width of divide ratio D (2..16)
- RESET_DIV, 2: divide ratio loaded into every channel at reset
- RESET_EN, 1: channel enable applied at the first edge after reset release

Ports:
- clk_i  in  1  source clock; the only clock
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  config request
- cfg_ready_o  out  1  config accept; handshake completes when valid && ready
- cfg_ch_i  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div_i  in  DIV_WIDTH  new ratio D
- cfg_en_i  in  1  new enable
- cfg_err_o  out  1  one-cycle pulse: accepted request had cfg_ch_i >= NUM_CH
- div_clk_o  out  NUM_CH  divided clocks, flop outputs
- tick_o  out  NUM_CH  one-cycle strobe coincident with each div_clk_o rising period
- pend_o  out  NUM_CH  channel holds an unapplied config
- cfg_done_o  out  NUM_CH  one-cycle pulse in the first cycle new settings are in effect

## Operation
- Per-channel state: active, div (DIV_WIDTH), cnt (DIV_WIDTH), pending {valid, div, en}.
- half = div >> 1. Invariants, every cycle: div_clk_o[c] == active && (cnt < half); tick_o[c] == active && (cnt == 0). Both are flops loaded from next-state values. They are never decoded combinationally.
- Active counting: at boundary (cnt == div-1, or div <= 1), cnt goes to 0. Otherwise cnt increments.
- D=4 gives div_clk 1,1,0,0. D=5 gives 1,1,0,0,0 (high floor(D/2) cycles). D=1 gives tick high every cycle and div_clk held 0. D=0 is treated as D=1.
- Config acceptance: cfg_ready_o = !pending.valid[cfg_ch_i]. It is 1 for out-of-range channels.
- Out-of-range channel: request is accepted and dropped; cfg_err_o pulses the next cycle.
- Accept to a halted channel: div and active load on the next edge with cnt=0 and pending bypassed. cfg_done_o pulses in that cycle.
  - If en=1, the channel starts with tick and, if half>0, div_clk high.
  - If en=0, only div is updated.
- Accept to an active channel: config goes to pending and pend_o is set.
- At the channel's next boundary, pending loads div/active, cnt goes to 0, pending clears, and cfg_done_o pulses in the following cycle (the first cycle under new settings).
- Disable therefore completes the current period, so div_clk_o always ends low.
- Simultaneous accept and boundary on the same channel: the config goes to pending and applies at the following boundary, not the current one.
- A pending entry is never overwritten; backpressure holds until it applies.
- Reset: active=0, cnt=0, div=RESET_DIV, pending clear. All outputs are 0 while rst_i=1. At the first edge with rst_i=0, RESET_EN applies as an enable to a halted channel, with no cfg_done_o.
- rst_i asserted mid-operation forces all outputs 0 at the next edge, with no phase completion.

## Timing
- Request-to-effect latency:
  - Halted channel: 1 cycle.
  - Active channel: boundary distance + 1 cycle, at most D+1 cycles.
- cfg_ready_o is combinational from cfg_ch_i and the pending flags. No combinational path runs from cfg inputs to div_clk_o, tick_o, or cfg_done_o.
- cfg_err_o, pend_o and cfg_done_o are all registered.
- Channels are fully independent. Accepts to different channels in consecutive cycles are each accepted at full rate.

## Test plan
- Reset release, RESET_DIV=2, RESET_EN=1 -> every channel shows div_clk 1,0 repeating from the first post-reset cycle, tick on each high cycle, cfg_done_o never pulses.
- Halted ch1, program D=5 en=1 -> next cycle div_clk 1,1,0,0,0 repeating, tick every 5 cycles, cfg_done_o[1] pulses once in that first cycle.
- Ch0 at D=4, program D=6 at cnt=1 -> pend_o[0]=1; the remaining 2 cycles of the old period complete; the 6-cycle period 1,1,1,0,0,0 starts with cfg_done_o[0] on its first cycle; pend_o clears.
- Pending on ch0, second request to ch0 -> cfg_ready_o=0 until the boundary; a request to ch2 in the same window is accepted immediately.
- Ch3 at D=8, disable at cnt=1 -> 6 more cycles of the period, div_clk ends low, channel held 0, no further ticks.
- cfg_ch_i=NUM_CH (NUM_CH not a power of 2) -> accepted, cfg_err_o pulses once, no channel state changes. Also: rst_i asserted mid-high phase -> all outputs 0 at the next edge.
